fetch_stage: RTL
================

# fetch_stage

Instruction fetch stage and IF/ID pipeline register of the SIMD processor: it owns the program counter, drives the synchronous instruction memory, and delivers one 24-bit instruction per cycle to the decoder stage. It honours downstream stalls, redirects on taken branches resolved downstream (squashing wrong-path fetches), and stops fetching on a HALT opcode.

## Interface
- ADDR_WIDTH, 16: PC / instruction-memory address width (matches 16-bit Immediate branch targets).
- INSTR_WIDTH, 24: instruction word width.
- RESET_PC, 0: PC value after reset.
- HALT_OPCODE, 4'hF: value of instruction[23:20] that halts fetching.
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset; highest priority.
- Start  in  1  begin fetching from IDLE.
- Stall  in  1  decoder cannot accept; hold IF/ID register and PC.
- BranchTaken  in  1  redirect request from downstream.
- BranchTarget  in  ADDR_WIDTH  redirect address.
- ImemAddr  out  ADDR_WIDTH  instruction-memory address (combinational from state).
- ImemData  in  INSTR_WIDTH  memory word for the address presented the previous cycle (1-cycle read latency).
- instruction  out  INSTR_WIDTH  IF/ID register to decoder.
- InstrValid  out  1  instruction holds a real, non-squashed instruction.
- PcOut  out  ADDR_WIDTH  address of instruction.
- Halted  out  1  high in HALTED state.
- FetchCount  out  32  number of instructions delivered (InstrValid captures).

## Operation
- Internal: P (next fetch PC), A (address whose data is on ImemData), AV (A valid), FSM {IDLE, RUN, HALTED}.
- Reset values: P=RESET_PC, A=0, AV=0, instruction=0, InstrValid=0, PcOut=0, state IDLE, Halted=0, FetchCount=0.
- ImemAddr = Stall ? A : P (re-presents the in-flight address so ImemData still matches A after the stall).
- IDLE: nothing advances; Start=1 -> RUN next edge.
- RUN, per edge, priority rst > BranchTaken > Stall > advance:
  - BranchTaken: P<=BranchTarget, AV<=0, InstrValid<=0 (squash); instruction/PcOut may change but are don't-care while InstrValid=0. Wins over Stall.
  - Stall: P, A, AV, instruction, PcOut, InstrValid all hold.
  - Advance: instruction<=ImemData, PcOut<=A, InstrValid<=AV; P<=P+1, A<=P, AV<=1; FetchCount+=AV.
  - If advance captures AV=1 and ImemData[23:20]==HALT_OPCODE: HALT delivered with InstrValid=1; state<=HALTED, AV<=0, P holds.
- HALTED: Halted=1; BranchTaken and Start ignored; on non-stalled edges InstrValid<=0; Stall still holds the IF/ID register (HALT stays presented until accepted). Exit only via rst.
- P increments modulo 2^ADDR_WIDTH (0xFFFF -> 0x0000, no flag). FetchCount wraps modulo 2^32.

## Timing
- Start sampled at edge k: first instruction (mem[RESET_PC]) visible with InstrValid=1 after edge k+2; thereafter one per cycle without stalls.
- Branch at edge b: InstrValid=0 after edges b and b+1; mem[BranchTarget] visible after edge b+2 (2-cycle bubble).
- Stall for n cycles: instruction/PcOut/InstrValid frozen n cycles, no instruction lost or duplicated.
- BranchTaken and HALT capture same edge: branch wins, HALT squashed, stay RUN.
- rst in any state/mid-stall: all state returns to reset values next edge; IDLE until Start.

## Test plan
- Reset/start: mem[i]=24'h000000+i for i<8; Start pulse -> InstrValid rises 2 edges later, PcOut 0,1,2,3 consecutive cycles, instruction matches, FetchCount=4 after 4 deliveries.
- Stall: assert Stall 3 cycles while PcOut=2 -> PcOut=2 held 4 cycles total, then 3,4; no skip/duplicate; FetchCount unaffected during stall.
- Branch: BranchTaken with BranchTarget=16'h0040 while PcOut=3 -> two InstrValid=0 cycles, then PcOut=0x40 with mem[0x40]; wrong-path 4,5 never valid.
- Branch+Stall same cycle -> redirect taken; branch same edge as HALT capture -> HALT squashed, Halted stays 0.
- HALT: mem[5]=24'hF00000 -> PcOut=5 delivered valid, Halted=1 next edge, InstrValid=0 afterwards; BranchTaken ignored; rst -> IDLE, P=RESET_PC, Halted=0.
- Wrap: BranchTarget=16'hFFFE -> PcOut FFFE, FFFF, 0000, 0001 consecutive valid cycles.

Source files
------------

// File: rtl/fetch_stage_if.sv
// +--------------------------------------------------------------------+
// | fetch_stage_if : fetch-stage control, imem and IF/ID bundle. Rev 1.0 |
// +--------------------------------------------------------------------+
`default_nettype none

interface fetch_stage_if #(
  parameter int ADDR_WIDTH  = 16,
  parameter int INSTR_WIDTH = 24
);
  logic                   Start;
  logic                   Stall;
  logic                   BranchTaken;
  logic [ADDR_WIDTH-1:0]  BranchTarget;
  logic [ADDR_WIDTH-1:0]  ImemAddr;
  logic [INSTR_WIDTH-1:0] ImemData;
  logic [INSTR_WIDTH-1:0] instruction;
  logic                   InstrValid;
  logic [ADDR_WIDTH-1:0]  PcOut;
  logic                   Halted;
  logic [31:0]            FetchCount;

  modport master (
    input  Start, Stall, BranchTaken, BranchTarget, ImemData,
    output ImemAddr, instruction, InstrValid, PcOut, Halted, FetchCount
  );

  modport slave (
    output Start, Stall, BranchTaken, BranchTarget, ImemData,
    input  ImemAddr, instruction, InstrValid, PcOut, Halted, FetchCount
  );
endinterface

`default_nettype wire

// File: rtl/fetch_stage.sv
// +--------------------------------------------------------------------+
// | fetch_stage : PC, sync imem driver and IF/ID register. Rev 1.0     |
// +--------------------------------------------------------------------+
`default_nettype none

module fetch_stage #(
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    INSTR_WIDTH = 24,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [3:0]            HALT_OPCODE = 4'hF
) (
  input  wire logic     clk,
  input  wire logic     rst,
  fetch_stage_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0]  r_p, w_p_nxt;
  logic [ADDR_WIDTH-1:0]  r_a, w_a_nxt;
  logic                   r_av, w_av_nxt;
  logic [INSTR_WIDTH-1:0] r_instr, w_instr_nxt;
  logic                   r_valid, w_valid_nxt;
  logic [ADDR_WIDTH-1:0]  r_pcout, w_pcout_nxt;
  logic [31:0]            r_count, w_count_nxt;
  logic                   w_is_halt;

  assign w_is_halt = (bus.ImemData[INSTR_WIDTH-1 -: 4] == HALT_OPCODE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_p     <= RESET_PC;
      r_a     <= '0;
      r_av    <= 1'b0;
      r_instr <= '0;
      r_valid <= 1'b0;
      r_pcout <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_p     <= w_p_nxt;
      r_a     <= w_a_nxt;
      r_av    <= w_av_nxt;
      r_instr <= w_instr_nxt;
      r_valid <= w_valid_nxt;
      r_pcout <= w_pcout_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_p_nxt     = r_p;
    w_a_nxt     = r_a;
    w_av_nxt    = r_av;
    w_instr_nxt = r_instr;
    w_valid_nxt = r_valid;
    w_pcout_nxt = r_pcout;
    w_count_nxt = r_count;
    case (r_state)
      ST_IDLE: begin
        if (bus.Start) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.BranchTaken) begin
          w_p_nxt     = bus.BranchTarget;
          w_av_nxt    = 1'b0;
          w_valid_nxt = 1'b0;
        end else if (!bus.Stall) begin
          w_instr_nxt = bus.ImemData;
          w_pcout_nxt = r_a;
          w_valid_nxt = r_av;
          w_count_nxt = r_count + 32'(r_av);
          if (r_av && w_is_halt) begin
            // HALT is delivered but nothing behind it is fetched.
            w_state_nxt = ST_HALTED;
            w_av_nxt    = 1'b0;
          end else begin
            w_p_nxt  = r_p + ADDR_WIDTH'(1);
            w_a_nxt  = r_p;
            w_av_nxt = 1'b1;
          end
        end
      end
      ST_HALTED: begin
        if (!bus.Stall) begin
          w_valid_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // While stalled the in-flight address is re-read so ImemData still matches r_a.
  assign bus.ImemAddr    = bus.Stall ? r_a : r_p;
  assign bus.instruction = r_instr;
  assign bus.InstrValid  = r_valid;
  assign bus.PcOut       = r_pcout;
  assign bus.Halted      = (r_state == ST_HALTED);
  assign bus.FetchCount  = r_count;

endmodule

`default_nettype wire
